// File: rtl/wb_stage_multibeat_pkg.sv
// Shared types and default widths for the vector-processor writeback stage.
//   dest_type_e : register bank selector (scalar / vector)
//   wb_state_e  : writeback sequencer states
//   wb_entry_t  : one buffered writeback request at default widths
//   beat_w()    : width of a beat index for a given beat count
package vp_pkg;

  localparam int unsigned SCALAR_W_D   = 21;
  localparam int unsigned ELEM_W_D     = 24;
  localparam int unsigned LANES_D      = 8;
  localparam int unsigned REG_ADDR_W_D = 4;
  localparam int unsigned BEATS_D      = 2;
  localparam int unsigned FIFO_DEPTH_D = 4;

  typedef enum logic {
    DEST_SCALAR = 1'b0,
    DEST_VECTOR = 1'b1
  } dest_type_e;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W_D-1:0]       dest;
    dest_type_e                    dest_type;
    logic [LANES_D-1:0]            lane_mask;
    logic [LANES_D*ELEM_W_D-1:0]   vdata;
    logic [SCALAR_W_D-1:0]         sdata;
  } wb_entry_t;

  // A single-beat configuration still gets a 1-bit beat index.
  function automatic int unsigned beat_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/wb_stage_multibeat_if.sv
// Bus bundle of the writeback stage.
//   in_*    : writeback request (valid/ready) from MEM
//   rf_*    : register-file write port, one scalar write or one vector beat per cycle
//   fwd_*   : forwarding view of the buffer head
//   done_*  : scoreboard release pulse
//   busy    : stage holds or is writing an entry
// slave modport faces the stage; master modport faces its environment.
interface wb_stage_multibeat_if
  import vp_pkg::*;
#(
  parameter int unsigned SCALAR_W   = SCALAR_W_D,
  parameter int unsigned ELEM_W     = ELEM_W_D,
  parameter int unsigned LANES      = LANES_D,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_D,
  parameter int unsigned BEATS      = BEATS_D
) ();

  localparam int unsigned BL     = LANES / BEATS;
  localparam int unsigned BEAT_W = beat_w(BEATS);
  localparam int unsigned VEC_W  = LANES * ELEM_W;

  logic                   in_valid;
  logic                   in_ready;
  logic [REG_ADDR_W-1:0]  in_dest;
  logic                   in_dest_type;
  logic                   in_sel_mem;
  logic [LANES-1:0]       in_lane_mask;
  logic [VEC_W-1:0]       in_mem_data;
  logic [VEC_W-1:0]       in_alu_v;
  logic [SCALAR_W-1:0]    in_alu_s;

  logic                   rf_we_s;
  logic                   rf_we_v;
  logic [REG_ADDR_W-1:0]  rf_addr;
  logic [SCALAR_W-1:0]    rf_wdata_s;
  logic [BEAT_W-1:0]      rf_beat;
  logic [BL*ELEM_W-1:0]   rf_wdata_v;
  logic [BL-1:0]          rf_lane_we;

  logic                   fwd_valid;
  logic [REG_ADDR_W-1:0]  fwd_dest;
  logic                   fwd_type;
  logic [VEC_W-1:0]       fwd_vector;
  logic [SCALAR_W-1:0]    fwd_scalar;

  logic                   done_valid;
  logic [REG_ADDR_W-1:0]  done_dest;
  logic                   done_type;
  logic                   busy;

  modport slave (
    input  in_valid, in_dest, in_dest_type, in_sel_mem, in_lane_mask,
           in_mem_data, in_alu_v, in_alu_s,
    output in_ready,
           rf_we_s, rf_we_v, rf_addr, rf_wdata_s, rf_beat, rf_wdata_v, rf_lane_we,
           fwd_valid, fwd_dest, fwd_type, fwd_vector, fwd_scalar,
           done_valid, done_dest, done_type, busy
  );

  modport master (
    output in_valid, in_dest, in_dest_type, in_sel_mem, in_lane_mask,
           in_mem_data, in_alu_v, in_alu_s,
    input  in_ready,
           rf_we_s, rf_we_v, rf_addr, rf_wdata_s, rf_beat, rf_wdata_v, rf_lane_we,
           fwd_valid, fwd_dest, fwd_type, fwd_vector, fwd_scalar,
           done_valid, done_dest, done_type, busy
  );

endinterface

// File: rtl/wb_stage_multibeat_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries.
//   clk, rst_n : clock, synchronous active-low reset (empties the buffer)
//   push, din  : write din when not full
//   pop        : drop head when not empty
//   full, empty, count : occupancy
//   head       : oldest entry (undefined content when empty)
module wb_fifo
  import vp_pkg::*;
#(
  parameter type         T     = wb_entry_t,
  parameter int unsigned DEPTH = FIFO_DEPTH_D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  T                mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage_multibeat.sv
// wb_stage_multibeat: writeback stage after MEM.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request, RF write, forwarding, release and busy signals
// Requests are muxed (mem vs ALU) at enqueue, buffered, and drained one per
// cycle: a scalar entry takes one RF write, a vector entry BEATS lane-group
// writes. The release pulse and pop coincide with an entry's final write.
module wb_stage_multibeat
  import vp_pkg::*;
#(
  parameter int unsigned SCALAR_W   = SCALAR_W_D,
  parameter int unsigned ELEM_W     = ELEM_W_D,
  parameter int unsigned LANES      = LANES_D,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_D,
  parameter int unsigned BEATS      = BEATS_D,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_D
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_stage_multibeat_if.slave bus
);

  localparam int unsigned BL     = LANES / BEATS;
  localparam int unsigned BEAT_W = beat_w(BEATS);
  localparam int unsigned VEC_W  = LANES * ELEM_W;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    dest_type_e            dest_type;
    logic [LANES-1:0]      lane_mask;
    logic [VEC_W-1:0]      vdata;
    logic [SCALAR_W-1:0]   sdata;
  } entry_t;

  entry_t            in_entry;
  entry_t            head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;

  wb_state_e         state;
  wb_state_e         state_n;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_n;
  logic              writing;
  logic              is_vec;
  logic              write_last;

  assign bus.in_ready = rst_n & ~full;
  assign push         = bus.in_valid & bus.in_ready;

  always_comb begin
    in_entry.dest      = bus.in_dest;
    in_entry.dest_type = dest_type_e'(bus.in_dest_type);
    in_entry.lane_mask = bus.in_lane_mask;
    in_entry.vdata     = bus.in_sel_mem ? bus.in_mem_data : bus.in_alu_v;
    in_entry.sdata     = bus.in_alu_s;
  end

  wb_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_entry),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WB_IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  // IDLE also looks at push so an entry accepted into an empty buffer is
  // written on the very next cycle. WRITE stays put across entries when
  // another one remains after the pop, giving bubble-free back-to-back drain.
  always_comb begin
    state_n    = state;
    beat_n     = beat;
    writing    = rst_n & (state == WB_WRITE) & ~empty;
    is_vec     = (head.dest_type == DEST_VECTOR);
    write_last = writing & (~is_vec | (beat == BEAT_W'(BEATS - 1)));
    pop        = write_last;
    case (state)
      WB_IDLE: begin
        if (~empty | push) begin
          state_n = WB_WRITE;
          beat_n  = '0;
        end
      end
      WB_WRITE: begin
        if (write_last) begin
          beat_n  = '0;
          state_n = ((count > CNT_W'(1)) | push) ? WB_WRITE : WB_IDLE;
        end else if (writing) begin
          beat_n = beat + BEAT_W'(1);
        end
      end
      default: begin
        state_n = WB_IDLE;
        beat_n  = '0;
      end
    endcase
  end

  always_comb begin
    bus.rf_we_s    = 1'b0;
    bus.rf_we_v    = 1'b0;
    bus.rf_addr    = '0;
    bus.rf_wdata_s = '0;
    bus.rf_beat    = '0;
    bus.rf_wdata_v = '0;
    bus.rf_lane_we = '0;
    if (writing) begin
      bus.rf_addr = head.dest;
      if (is_vec) begin
        bus.rf_we_v = 1'b1;
        bus.rf_beat = beat;
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (beat == BEAT_W'(b)) begin
            bus.rf_wdata_v = head.vdata[b*BL*ELEM_W +: BL*ELEM_W];
            bus.rf_lane_we = head.lane_mask[b*BL +: BL];
          end
        end
      end else begin
        bus.rf_we_s    = 1'b1;
        bus.rf_wdata_s = head.sdata;
      end
    end
  end

  always_comb begin
    bus.done_valid = write_last;
    bus.done_dest  = '0;
    bus.done_type  = 1'b0;
    if (write_last) begin
      bus.done_dest = head.dest;
      bus.done_type = head.dest_type;
    end

    bus.fwd_valid  = 1'b0;
    bus.fwd_dest   = '0;
    bus.fwd_type   = 1'b0;
    bus.fwd_vector = '0;
    bus.fwd_scalar = '0;
    if (rst_n & ~empty) begin
      bus.fwd_valid  = 1'b1;
      bus.fwd_dest   = head.dest;
      bus.fwd_type   = head.dest_type;
      bus.fwd_vector = head.vdata;
      bus.fwd_scalar = head.sdata;
    end

    bus.busy = rst_n & (~empty | (state == WB_WRITE));
  end

endmodule
